memory_responder: RTL and testbench

//  Dual-port word memory answering the pipelined datapath's two memory-initiator ports.

---
 rtl/memory_responder.sv | 178 +++++++++++++++++
 tb/tb_memory_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: dual-port word memory for the datapath's fetch (port 1) and data (port 2) initiators.
// Ports: clk/reset; read_m1/address1 -> data1/inst_ready (fetch, read-only);
//        read_m2/write_m2/address2/data2(inout) -> data_ready (load/store on a shared data bus).
// Each port runs IDLE -> BUSY -> RESP with a fixed LATENCY and pulses its ready for one cycle per access.
// Optional build macro MEM_RESPONDER_STATS_EN adds num_fetch/num_load/num_store access counters.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module memory_responder #(
  parameter int LATENCY   = 4,  // 1..15
  parameter int ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_m1,
  input  logic [`WORD_SIZE-1:0] address1,
  output logic [`WORD_SIZE-1:0] data1,
  output logic                  inst_ready,
  input  logic                  read_m2,
  input  logic                  write_m2,
  input  logic [`WORD_SIZE-1:0] address2,
  inout  wire  [`WORD_SIZE-1:0] data2,
  output logic                  data_ready
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [`WORD_SIZE-1:0] num_fetch,
  output logic [`WORD_SIZE-1:0] num_load,
  output logic [`WORD_SIZE-1:0] num_store
`endif
);

  localparam int W         = `WORD_SIZE;
  localparam int MEM_DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  logic [W-1:0] r_mem [0:MEM_DEPTH-1];

  // Port 1 (fetch) state
  state_t               r_st1;
  logic [3:0]           r_cnt1;
  logic [ADDR_BITS-1:0] r_addr1;

  // Port 2 (data) state
  state_t               r_st2;
  logic [3:0]           r_cnt2;
  logic [ADDR_BITS-1:0] r_addr2;
  logic                 r_wr2;
  logic [W-1:0]         r_wdata2;
  logic [W-1:0]         r_rdata2;
  logic                 r_drv2;

  logic                 w_acc1, w_go1, w_acc2, w_go2, w_wr2;
  logic [ADDR_BITS-1:0] w_addr1, w_addr2;
  logic [W-1:0]         w_wdata2;
  logic                 w_unused_addr;

  // Upper address bits are deliberately ignored: the array wraps modulo MEM_DEPTH.
  assign w_unused_addr = ^{address1, address2};

  // Acceptance happens only in IDLE; w_go marks the edge that enters RESP, which is
  // the single edge where the array is read or written. With LATENCY==1 that is the
  // acceptance edge itself, so the live request inputs are used instead of the latches.
  assign w_acc1  = (r_st1 == S_IDLE) && read_m1;
  assign w_go1   = !reset && ((w_acc1 && (LATENCY == 1)) || ((r_st1 == S_BUSY) && (r_cnt1 == 4'd0)));
  assign w_addr1 = (r_st1 == S_IDLE) ? address1[ADDR_BITS-1:0] : r_addr1;

  assign w_acc2   = (r_st2 == S_IDLE) && (read_m2 || write_m2);
  assign w_go2    = !reset && ((w_acc2 && (LATENCY == 1)) || ((r_st2 == S_BUSY) && (r_cnt2 == 4'd0)));
  assign w_addr2  = (r_st2 == S_IDLE) ? address2[ADDR_BITS-1:0] : r_addr2;
  assign w_wr2    = (r_st2 == S_IDLE) ? write_m2 : r_wr2;  // write wins when both are high
  assign w_wdata2 = (r_st2 == S_IDLE) ? data2 : r_wdata2;

  // Array commit. A fetch capturing the same word on this edge sees the old value
  // because both sides use non-blocking updates.
  always_ff @(posedge clk) begin
    if (w_go2 && w_wr2) begin
      r_mem[w_addr2] <= w_wdata2;
    end
  end

  // Port 1 FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st1      <= S_IDLE;
      r_cnt1     <= 4'd0;
      r_addr1    <= '0;
      data1      <= '0;
      inst_ready <= 1'b0;
    end else begin
      inst_ready <= w_go1;
      if (w_go1) begin
        data1 <= r_mem[w_addr1];
      end
      case (r_st1)
        S_IDLE: begin
          if (w_acc1) begin
            r_addr1 <= address1[ADDR_BITS-1:0];
            r_cnt1  <= 4'(LATENCY - 1);
            r_st1   <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt1 == 4'd0) begin
            r_st1 <= S_RESP;
          end else begin
            r_cnt1 <= r_cnt1 - 4'd1;
          end
        end
        S_RESP:  r_st1 <= S_IDLE;
        default: r_st1 <= S_IDLE;
      endcase
    end
  end

  // Port 2 FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st2      <= S_IDLE;
      r_cnt2     <= 4'd0;
      r_addr2    <= '0;
      r_wr2      <= 1'b0;
      r_wdata2   <= '0;
      r_rdata2   <= '0;
      r_drv2     <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= w_go2;
      r_drv2     <= w_go2 && !w_wr2;
      if (w_go2 && !w_wr2) begin
        r_rdata2 <= r_mem[w_addr2];
      end
      case (r_st2)
        S_IDLE: begin
          if (w_acc2) begin
            r_addr2  <= address2[ADDR_BITS-1:0];
            r_wr2    <= write_m2;
            r_wdata2 <= data2;
            r_cnt2   <= 4'(LATENCY - 1);
            r_st2    <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt2 == 4'd0) begin
            r_st2 <= S_RESP;
          end else begin
            r_cnt2 <= r_cnt2 - 4'd1;
          end
        end
        S_RESP:  r_st2 <= S_IDLE;
        default: r_st2 <= S_IDLE;
      endcase
    end
  end

  // data2 is driven only during a load's RESP cycle.
  assign data2 = r_drv2 ? r_rdata2 : {W{1'bz}};

`ifdef MEM_RESPONDER_STATS_EN
  localparam logic [W-1:0] ONE = 1;

  // Counters step on the same edge that raises the ready pulse; they wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_fetch <= '0;
      num_load  <= '0;
      num_store <= '0;
    end else begin
      if (w_go1)           num_fetch <= num_fetch + ONE;
      if (w_go2 && !w_wr2) num_load  <= num_load + ONE;
      if (w_go2 && w_wr2)  num_store <= num_store + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder: randomized and directed accesses on a LATENCY=4 instance,
// checked by a scoreboard against an array model, plus a LATENCY=1 instance for the
// same-edge collision and back-to-back timing.
module tb_memory_responder;

  localparam int L = 4;
  localparam int D = (L == 1) ? 0 : L;  // edges from acceptance edge to the RESP-entry edge

  logic        clk = 1'b0;
  logic        reset;
  logic        read_m1, read_m2, write_m2;
  logic [15:0] address1, address2;
  logic [15:0] data1;
  wire  [15:0] data2;
  logic        inst_ready, data_ready;
  logic [15:0] tb_d2;
  logic        tb_d2_en;
  assign data2 = tb_d2_en ? tb_d2 : 16'hzzzz;

  // LATENCY=1 instance
  logic        read_m1b, read_m2b, write_m2b;
  logic [15:0] address1b, address2b, data1b;
  wire  [15:0] data2b;
  logic        inst_readyb, data_readyb;
  logic [15:0] d2b;
  logic        d2b_en;
  assign data2b = d2b_en ? d2b : 16'hzzzz;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] num_fetch, num_load, num_store;
  logic [15:0] num_fetch_b, num_load_b, num_store_b;
`endif

  memory_responder #(.LATENCY(L), .ADDR_BITS(8)) u_dut (
    .clk(clk), .reset(reset),
    .read_m1(read_m1), .address1(address1), .data1(data1), .inst_ready(inst_ready),
    .read_m2(read_m2), .write_m2(write_m2), .address2(address2), .data2(data2),
    .data_ready(data_ready)
`ifdef MEM_RESPONDER_STATS_EN
    , .num_fetch(num_fetch), .num_load(num_load), .num_store(num_store)
`endif
  );

  memory_responder #(.LATENCY(1), .ADDR_BITS(8)) u_lat1 (
    .clk(clk), .reset(reset),
    .read_m1(read_m1b), .address1(address1b), .data1(data1b), .inst_ready(inst_readyb),
    .read_m2(read_m2b), .write_m2(write_m2b), .address2(address2b), .data2(data2b),
    .data_ready(data_readyb)
`ifdef MEM_RESPONDER_STATS_EN
    , .num_fetch(num_fetch_b), .num_load(num_load_b), .num_store(num_store_b)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: word array plus expected responses in issue order per port.
  typedef struct packed { logic [15:0] dat; int cyc; logic rd; } exp_t;
  exp_t        q1[$];
  exp_t        q2[$];
  logic [15:0] mem_m [256];
  int          n_fetch = 0, n_load = 0, n_store = 0;

  // Per-port driver bookkeeping: p_a = cycle of expected RESP, p_ok = first cycle the port is idle again.
  int p1_ok = 0, p1_a = 0, p2_ok = 0, p2_a = 0;
  bit p1_hold = 0, p2_hold = 0, p2_rd = 0;

  // Monitor
  bit          mon_en = 0;
  logic [15:0] last1 = 16'h0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (inst_ready) begin
        if (q1.size() == 0) chk("inst_ready_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("fetch_cycle", cyc, e.cyc);
          chk("fetch_data1", data1, e.dat);
          last1 = e.dat;
        end
      end else begin
        chk("data1_hold", data1, last1);
      end
      if (data_ready) begin
        if (q2.size() == 0) chk("data_ready_unexpected", 1, 0);
        else begin
          e = q2.pop_front();
          chk("data_cycle", cyc, e.cyc);
          if (e.rd) chk("load_data2", data2, e.dat);
        end
      end
      if (tb_d2_en && tb_d2 == 16'h0) chk("data2_released", data2, 16'h0);
    end
  end

  // Housekeeping after each edge: drop or scramble request lines, manage the data2 bus.
  task automatic tend();
    if (cyc >= p1_ok) read_m1 = 1'b0;
    else if (!p1_hold) read_m1 = 1'b0;
    else begin read_m1 = 1'($urandom); address1 = 16'($urandom); end

    if (cyc >= p2_ok) begin
      read_m2 = 1'b0; write_m2 = 1'b0; tb_d2 = 16'h0; tb_d2_en = 1'b1;
    end else begin
      if (!p2_hold) begin read_m2 = 1'b0; write_m2 = 1'b0; end
      else begin read_m2 = 1'($urandom); write_m2 = 1'($urandom); address2 = 16'($urandom); end
      if (p2_rd && cyc == p2_a) tb_d2_en = 1'b0;
      else if (!p2_rd && p2_hold) begin tb_d2_en = 1'b1; tb_d2 = 16'($urandom); end
      else begin tb_d2_en = 1'b1; tb_d2 = 16'h0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tend();
  endtask

  task automatic issue1(input logic [15:0] a, input bit hold);
    exp_t e;
    read_m1 = 1'b1; address1 = a; p1_hold = hold;
    p1_a = cyc + 1 + D; p1_ok = p1_a + 1;
    e.dat = mem_m[a[7:0]]; e.cyc = p1_a; e.rd = 1'b1;
    q1.push_back(e);
    n_fetch++;
  endtask

  task automatic issue2(input bit rd, input bit both, input logic [15:0] a, input logic [15:0] wd,
                        input bit hold);
    exp_t e;
    address2 = a; p2_hold = hold; p2_rd = rd;
    p2_a = cyc + 1 + D; p2_ok = p2_a + 1;
    e.cyc = p2_a; e.rd = rd;
    if (rd) begin
      read_m2 = 1'b1; write_m2 = 1'b0;
      e.dat = mem_m[a[7:0]];
      n_load++;
    end else begin
      read_m2 = both; write_m2 = 1'b1; tb_d2 = wd; tb_d2_en = 1'b1;
      mem_m[a[7:0]] = wd;
      e.dat = 16'h0;
      n_store++;
    end
    q2.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || cyc < p1_ok || cyc < p2_ok) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s drain timeout: q1=%0d q2=%0d outstanding, required 0", nm, q1.size(), q2.size());
      q1.delete(); q2.delete();
    end
  endtask

  function automatic logic [15:0] raddr();
    logic [15:0] a;
    a = 16'($urandom);
    a[7:0] = 8'($urandom_range(0, 7));
    return a;
  endfunction

  // One access on the LATENCY=1 instance: RESP follows the acceptance edge immediately.
  task automatic b_op(input bit f, input bit w, input bit r, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp1, input logic [15:0] exp2);
    read_m1b = f; address1b = a; write_m2b = w; read_m2b = r; address2b = a;
    d2b = w ? wd : 16'h0; d2b_en = !r;
    step();
    @(negedge clk);
    chk("b_inst_ready", inst_readyb, f);
    chk("b_data_ready", data_readyb, w | r);
    if (f) chk("b_data1", data1b, exp1);
    if (r) chk("b_data2", data2b, exp2);
    read_m1b = 1'b0; write_m2b = 1'b0; read_m2b = 1'b0; d2b = 16'h0; d2b_en = 1'b1;
    step();
    @(negedge clk);
    chk("b_ready_clear", {inst_readyb, data_readyb}, 2'b00);
    chk("b_data2_released", data2b, 16'h0);
  endtask

  initial begin
    logic [15:0] old7;
    int op;
    reset = 1'b1;
    read_m1 = 0; read_m2 = 0; write_m2 = 0; address1 = 0; address2 = 0;
    tb_d2 = 0; tb_d2_en = 1'b1;
    read_m1b = 0; read_m2b = 0; write_m2b = 0; address1b = 0; address2b = 0;
    d2b = 0; d2b_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst_ready", inst_ready, 0);
    chk("reset_data_ready", data_ready, 0);
    chk("reset_data1", data1, 16'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Fill the whole array through port 2 (upper address bits random: they must be ignored).
    for (int i = 0; i < 256; i++) begin
      step();
      while (cyc < p2_ok) step();
      issue2(0, 0, {8'($urandom), 8'(i)}, 16'($urandom), 0);
    end
    drain("fill");

    // Directed: fetch of a known word, store/load pair, wrap, both-high, same-edge collision.
    step(); issue2(0, 0, 16'h0005, 16'h1234, 0); drain("preload5");
    step(); issue1(16'h0005, 0);                 drain("fetch5");
    step(); issue2(0, 0, 16'h0010, 16'hBEEF, 0); drain("store10");
    step(); issue2(1, 0, 16'h0010, 16'h0, 0);    drain("load10");
    step(); issue2(1, 0, 16'h0105, 16'h0, 0);    drain("wrap_load");
    step(); issue2(0, 1, 16'h0020, 16'h5A5A, 0); drain("both_high");
    step(); issue2(1, 0, 16'h0020, 16'h0, 0);    drain("both_check");
    step(); issue1(16'h0033, 0); issue2(0, 0, 16'h0133, 16'hC0DE, 0); drain("collision");
    step(); issue1(16'h0033, 0);                 drain("after_collision");

    // Randomized traffic over a small address window to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      step();
      if (cyc >= p1_ok && $urandom_range(0, 2) != 0) issue1(raddr(), $urandom_range(0, 3) == 0);
      if (cyc >= p2_ok && $urandom_range(0, 2) != 0) begin
        op = $urandom_range(0, 3);
        issue2(op < 2, op == 3, raddr(), 16'($urandom), $urandom_range(0, 3) == 0);
      end
    end
    drain("random");

    // LATENCY=1 instance: preload, same-edge collision, later fetch, wrapped load.
    b_op(0, 1, 0, 16'h0003, 16'h0001, 16'h0, 16'h0);
    b_op(1, 1, 0, 16'h0003, 16'h00FF, 16'h0001, 16'h0);
    b_op(1, 0, 0, 16'h0003, 16'h0, 16'h00FF, 16'h0);
    b_op(0, 0, 1, 16'h0103, 16'h0, 16'h0, 16'h00FF);

    // Reset during a store: no pulse, no array write, outputs cleared.
    old7 = mem_m[7];
    step();
    write_m2 = 1'b1; address2 = 16'h0007; tb_d2 = 16'hAAAA; tb_d2_en = 1'b1;
    step();
    step();
    reset = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("abort_data1", data1, 16'h0);
    chk("abort_inst_ready", inst_ready, 0);
    chk("abort_data_ready", data_ready, 0);
    last1 = 16'h0;
    n_fetch = 0; n_load = 0; n_store = 0;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (L + 3) step();
    chk("abort_model_word", mem_m[7], old7);
    step(); issue1(16'h0007, 0); drain("after_abort");
    step(); issue2(1, 0, 16'h0207, 16'h0, 0); drain("after_abort_load");

`ifdef MEM_RESPONDER_STATS_EN
    chk("num_fetch", num_fetch, 16'(n_fetch));
    chk("num_load", num_load, 16'(n_load));
    chk("num_store", num_store, 16'(n_store));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
